// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: LSU access sizes, arbiter FSM states,
// transaction owner, and the LSU alignment rule used at accept time.
package mem_pkg;

  typedef enum logic [1:0] {
    SzB   = 2'd0,
    SzH   = 2'd1,
    SzW   = 2'd2,
    SzIll = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

  // Illegal size or an address not naturally aligned to the access size.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic res;
    case (size)
      SzB:     res = 1'b0;
      SzH:     res = addr_lo[0];
      SzW:     res = (addr_lo != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational LSU lane logic.
//  addr_lo_i/size_i  byte offset and access size
//  uns_i             load zero-extend (1) / sign-extend (0)
//  wdata_i           right-justified store data
//  rdata_i           raw RAM word
//  wmask_o/wdata_o   byte enables and lane-replicated store data
//  misalign_o        access violates size/alignment rules
//  rdata_o           extracted and extended load data
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign misalign_o = misaligned(addr_lo_i, size_i);
  assign shifted    = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    wmask_o = 4'b0000;
    wdata_o = '0;
    rdata_o = rdata_i;
    case (size_i)
      SzB: begin
        wmask_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SzH: begin
        wmask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = uns_i ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SzW: begin
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between IFU and LSU.
// One transaction in flight: accept (IDLE) -> ISSUE -> WAIT -> RESP.
//  ifu_*  fetch request/response (word reads only)
//  lsu_*  load/store request/response with sub-word handling and error reply
//  ram_*  RAM master port; ram_rdata_i valid RAM_LAT cycles after ram_en_o
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_resp_valid_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  output logic        lsu_resp_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_err_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_wmask_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  arb_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  owner_e      owner_q, last_grant_q;
  logic [31:0] addr_q, wdata_q, ifu_rdata_q, lsu_rdata_q;
  logic [1:0]  size_q;
  logic        we_q, uns_q, err_q;

  logic        grant_lsu, grant_ifu, in_idle, hs_ifu, hs_lsu;
  logic        resp_ifu, resp_lsu;
  logic [1:0]  al_addr_lo, al_size;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata, al_rdata, lsu_resp_data;
  logic        al_misalign;

  // Tie goes to whoever was not granted last; last_grant resets to IFU so LSU wins first.
  assign grant_lsu = lsu_req_valid_i & (~ifu_req_valid_i | (last_grant_q == OwnIfu));
  assign grant_ifu = ifu_req_valid_i & ~grant_lsu;
  // Gating with rst_ni keeps readies low while reset is held.
  assign in_idle   = (state_q == StIdle) & rst_ni;

  assign ifu_req_ready_o = in_idle & grant_ifu;
  assign lsu_req_ready_o = in_idle & grant_lsu;
  assign hs_ifu = ifu_req_valid_i & ifu_req_ready_o;
  assign hs_lsu = lsu_req_valid_i & lsu_req_ready_o;

  // In IDLE the aligner checks the incoming request; afterwards it serves the latched one.
  assign al_addr_lo = (state_q == StIdle) ? lsu_addr_i[1:0] : addr_q[1:0];
  assign al_size    = (state_q == StIdle) ? lsu_size_i      : size_q;

  lsu_align u_lsu_align (
    .addr_lo_i  (al_addr_lo),
    .size_i     (al_size),
    .uns_i      (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (ram_rdata_i),
    .wmask_o    (al_wmask),
    .wdata_o    (al_wdata),
    .misalign_o (al_misalign),
    .rdata_o    (al_rdata)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hs_lsu)      state_d = al_misalign ? StResp : StIssue;
        else if (hs_ifu) state_d = StIssue;
      end
      StIssue: begin
        if ((owner_q == OwnLsu && we_q) || RAM_LAT <= 1) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = 2'(RAM_LAT - 1);
        end
      end
      StWait: begin
        // Leaving on cnt==1 puts RESP exactly RAM_LAT cycles after ISSUE.
        if (cnt_q <= 2'd1) state_d = StResp;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, arbitration history and response data hold registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q      <= OwnIfu;
      last_grant_q <= OwnIfu;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      if (hs_lsu) begin
        owner_q      <= OwnLsu;
        last_grant_q <= OwnLsu;
        addr_q       <= lsu_addr_i;
        wdata_q      <= lsu_wdata_i;
        size_q       <= lsu_size_i;
        we_q         <= lsu_we_i;
        uns_q        <= lsu_unsigned_i;
        err_q        <= al_misalign;
      end else if (hs_ifu) begin
        owner_q      <= OwnIfu;
        last_grant_q <= OwnIfu;
        addr_q       <= ifu_addr_i;
        wdata_q      <= '0;
        size_q       <= SzW;
        we_q         <= 1'b0;
        uns_q        <= 1'b0;
        err_q        <= 1'b0;
      end
      if (resp_ifu) ifu_rdata_q <= ram_rdata_i;
      if (resp_lsu) lsu_rdata_q <= lsu_resp_data;
    end
  end

  // Outputs.
  assign resp_ifu      = (state_q == StResp) & (owner_q == OwnIfu);
  assign resp_lsu      = (state_q == StResp) & (owner_q == OwnLsu);
  assign lsu_resp_data = (err_q | we_q) ? 32'd0 : al_rdata;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_wmask_o = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (state_q == StIssue) begin
      ram_en_o   = 1'b1;
      ram_addr_o = {addr_q[31:2], 2'b00};
      if (owner_q == OwnLsu && we_q) begin
        ram_we_o    = 1'b1;
        ram_wmask_o = al_wmask;
        ram_wdata_o = al_wdata;
      end
    end
  end

  // Response data is live during the pulse and held afterwards.
  assign ifu_resp_valid_o = resp_ifu;
  assign ifu_rdata_o      = resp_ifu ? ram_rdata_i : ifu_rdata_q;
  assign lsu_resp_valid_o = resp_lsu;
  assign lsu_resp_err_o   = resp_lsu & err_q;
  assign lsu_rdata_o      = resp_lsu ? lsu_resp_data : lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (RAM_LAT 1, 3, 4) share the
// request inputs; each has its own RAM latency model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, lsu_req_valid, lsu_we, lsu_unsigned;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, rd_word;
  logic [1:0]  lsu_size;

  logic        ifu_req_ready [3];
  logic        ifu_resp_valid [3];
  logic [31:0] ifu_rdata [3];
  logic        lsu_req_ready [3];
  logic        lsu_resp_valid [3];
  logic [31:0] lsu_rdata [3];
  logic        lsu_resp_err [3];
  logic        ram_en [3];
  logic        ram_we [3];
  logic [3:0]  ram_wmask [3];
  logic [31:0] ram_addr [3];
  logic [31:0] ram_wdata [3];
  logic [31:0] ram_rdata [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [3:0] en_pipe;

    mem_arbiter #(.RAM_LAT(Lat)) u_dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .ifu_req_valid_i  (ifu_req_valid),
      .ifu_req_ready_o  (ifu_req_ready[g]),
      .ifu_addr_i       (ifu_addr),
      .ifu_resp_valid_o (ifu_resp_valid[g]),
      .ifu_rdata_o      (ifu_rdata[g]),
      .lsu_req_valid_i  (lsu_req_valid),
      .lsu_req_ready_o  (lsu_req_ready[g]),
      .lsu_we_i         (lsu_we),
      .lsu_addr_i       (lsu_addr),
      .lsu_wdata_i      (lsu_wdata),
      .lsu_size_i       (lsu_size),
      .lsu_unsigned_i   (lsu_unsigned),
      .lsu_resp_valid_o (lsu_resp_valid[g]),
      .lsu_rdata_o      (lsu_rdata[g]),
      .lsu_resp_err_o   (lsu_resp_err[g]),
      .ram_en_o         (ram_en[g]),
      .ram_we_o         (ram_we[g]),
      .ram_wmask_o      (ram_wmask[g]),
      .ram_addr_o       (ram_addr[g]),
      .ram_wdata_o      (ram_wdata[g]),
      .ram_rdata_i      (ram_rdata[g])
    );

    // RAM model: word valid exactly Lat cycles after ram_en, garbage otherwise.
    always_ff @(posedge clk) begin
      if (!rst_n) en_pipe <= '0;
      else        en_pipe <= {en_pipe[2:0], ram_en[g]};
    end
    assign ram_rdata[g] = en_pipe[Lat-1] ? rd_word : 32'hDEADBEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_unsigned = 1'b0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_size = 2'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issues one request, waits for the handshake on instance inst, then records
  // the ram_en strobes and the owner's response over a fixed window.
  task automatic run_req(input int inst, input bit is_ifu, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit uns,
                         output int hs, output int en_cnt, output int en_c, output int rsp_c,
                         output logic [31:0] rdata, output logic err,
                         output logic [3:0] msk, output logic [31:0] wd,
                         output logic [31:0] ra, output logic rwe, output int wrong);
    hs = -1; en_cnt = 0; en_c = -1; rsp_c = -1; wrong = 0;
    rdata = 'x; err = 1'bx; msk = 'x; wd = 'x; ra = 'x; rwe = 1'bx;
    @(posedge clk); #1;
    if (is_ifu) begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end else begin
      lsu_req_valid = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
      lsu_size = size; lsu_unsigned = uns;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (is_ifu ? ifu_req_ready[inst] : lsu_req_ready[inst]) begin
        hs = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    if (hs < 0) begin
      check_eq("handshake_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ram_en[inst]) begin
        en_cnt++;
        en_c = cyc; msk = ram_wmask[inst]; wd = ram_wdata[inst];
        ra = ram_addr[inst]; rwe = ram_we[inst];
      end
      if (is_ifu) begin
        if (ifu_resp_valid[inst] && rsp_c < 0) begin
          rsp_c = cyc; rdata = ifu_rdata[inst]; err = 1'b0;
        end
        if (lsu_resp_valid[inst]) wrong++;
      end else begin
        if (lsu_resp_valid[inst] && rsp_c < 0) begin
          rsp_c = cyc; rdata = lsu_rdata[inst]; err = lsu_resp_err[inst];
        end
        if (ifu_resp_valid[inst]) wrong++;
      end
    end
  endtask

  int          hs, en_cnt, en_c, rsp_c, wrong, both, ngr, hits;
  logic [31:0] rdata, wd, ra;
  logic [3:0]  msk;
  logic        err, rwe;
  bit          gr [6];

  initial begin
    rd_word = 32'h0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state, with a request pending to show readies stay low under reset.
    repeat (2) @(posedge clk);
    #1 lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_ifu_ready", 32'(ifu_req_ready[0]), 32'd0);
    check_eq("rst_lsu_ready", 32'(lsu_req_ready[0]), 32'd0);
    check_eq("rst_ifu_resp", 32'(ifu_resp_valid[0]), 32'd0);
    check_eq("rst_lsu_resp", 32'(lsu_resp_valid[0]), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en[0]), 32'd0);
    check_eq("rst_ram_addr", ram_addr[0], 32'd0);
    check_eq("rst_ifu_rdata", ifu_rdata[0], 32'd0);
    check_eq("rst_lsu_rdata", lsu_rdata[0], 32'd0);
    idle_inputs();

    // Contention from reset: LSU first, then strict alternation.
    do_reset();
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h20;
    lsu_req_valid = 1'b1; lsu_addr = 32'h10; lsu_size = 2'd2;
    both = 0; ngr = 0;
    for (int i = 0; i < 60 && ngr < 6; i++) begin
      @(negedge clk);
      if (ifu_req_ready[0] && lsu_req_ready[0]) both++;
      if (lsu_req_ready[0])      begin gr[ngr] = 1'b1; ngr++; end
      else if (ifu_req_ready[0]) begin gr[ngr] = 1'b0; ngr++; end
    end
    check_eq("grant_count", 32'(ngr), 32'd6);
    check_eq("grant_both", 32'(both), 32'd0);
    for (int i = 0; i < ngr; i++) check_eq($sformatf("grant_lsu_%0d", i), 32'(gr[i]),
                                           32'((i % 2) == 0));
    idle_inputs();

    // sb 0x1003: lane 3, replicated data, response 2 cycles after handshake cycle.
    do_reset();
    run_req(0, 0, 1, 32'h1003, 32'h000000AB, 2'd0, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("sb_en_cnt", 32'(en_cnt), 32'd1);
    check_eq("sb_en_cyc", 32'(en_c), 32'(hs + 1));
    check_eq("sb_wmask", 32'(msk), 32'b1000);
    check_eq("sb_wdata", wd, 32'hABABABAB);
    check_eq("sb_addr", ra, 32'h1000);
    check_eq("sb_we", 32'(rwe), 32'd1);
    check_eq("sb_rsp_cyc", 32'(rsp_c), 32'(hs + 2));
    check_eq("sb_rdata", rdata, 32'd0);
    check_eq("sb_err", 32'(err), 32'd0);
    check_eq("sb_wrong_owner", 32'(wrong), 32'd0);

    // sh 0x2002 and sw 0x2004 lane patterns.
    do_reset();
    run_req(0, 0, 1, 32'h2002, 32'hFFFF1234, 2'd1, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("sh_wmask", 32'(msk), 32'b1100);
    check_eq("sh_wdata", wd, 32'h12341234);
    do_reset();
    run_req(0, 0, 1, 32'h2004, 32'h89ABCDEF, 2'd2, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("sw_wmask", 32'(msk), 32'b1111);
    check_eq("sw_wdata", wd, 32'h89ABCDEF);
    check_eq("sw_addr", ra, 32'h2004);

    // Loads from 0x2002 with RAM word 0x00F00000.
    rd_word = 32'h00F00000;
    do_reset();
    run_req(0, 0, 0, 32'h2002, 32'h0, 2'd0, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("lb_rdata", rdata, 32'hFFFFFFF0);
    check_eq("lb_rsp_cyc", 32'(rsp_c), 32'(hs + 2));
    check_eq("lb_wmask", 32'(msk), 32'd0);
    check_eq("lb_we", 32'(rwe), 32'd0);
    check_eq("lb_addr", ra, 32'h2000);
    do_reset();
    run_req(0, 0, 0, 32'h2002, 32'h0, 2'd0, 1,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("lbu_rdata", rdata, 32'h000000F0);
    do_reset();
    run_req(0, 0, 0, 32'h2002, 32'h0, 2'd1, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("lh_rdata", rdata, 32'h000000F0);
    rd_word = 32'h80000000;
    do_reset();
    run_req(0, 0, 0, 32'h2002, 32'h0, 2'd1, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("lh_neg_rdata", rdata, 32'hFFFF8000);
    check_eq("lh_held", lsu_rdata[0], 32'hFFFF8000);

    // Misaligned lw and illegal size: error reply, no RAM access.
    do_reset();
    run_req(0, 0, 0, 32'h2001, 32'h0, 2'd2, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("lw_mis_err", 32'(err), 32'd1);
    check_eq("lw_mis_rdata", rdata, 32'd0);
    check_eq("lw_mis_en_cnt", 32'(en_cnt), 32'd0);
    check_eq("lw_mis_rsp_cyc", 32'(rsp_c), 32'(hs + 1));
    do_reset();
    run_req(0, 0, 1, 32'h3000, 32'h55, 2'd3, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("sz3_err", 32'(err), 32'd1);
    check_eq("sz3_en_cnt", 32'(en_cnt), 32'd0);

    // RAM_LAT=4 fetch: response exactly 4 cycles after ram_en, data held afterwards.
    rd_word = 32'hCAFEF00D;
    do_reset();
    run_req(2, 1, 0, 32'h80000000, 32'h0, 2'd0, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("f4_en_cyc", 32'(en_c), 32'(hs + 1));
    check_eq("f4_rsp_cyc", 32'(rsp_c), 32'(en_c + 4));
    check_eq("f4_rdata", rdata, 32'hCAFEF00D);
    check_eq("f4_addr", ra, 32'h80000000);
    check_eq("f4_we", 32'(rwe), 32'd0);
    check_eq("f4_wrong_owner", 32'(wrong), 32'd0);
    check_eq("f4_held", ifu_rdata[2], 32'hCAFEF00D);

    // Reset in the middle of a RAM_LAT=3 wait.
    rd_word = 32'h11112222;
    do_reset();
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h40;
    hits = 0;
    for (int i = 0; i < 10 && hits == 0; i++) begin
      @(negedge clk);
      if (ifu_req_ready[1]) hits = 1;
    end
    check_eq("mw_handshake", 32'(hits), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_eq("mw_issue", 32'(ram_en[1]), 32'd1);
    @(posedge clk); #1;
    lsu_req_valid = 1'b1; lsu_size = 2'd2;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mw_rst_ram_en", 32'(ram_en[1]), 32'd0);
    check_eq("mw_rst_lsu_ready", 32'(lsu_req_ready[1]), 32'd0);
    check_eq("mw_rst_ifu_resp", 32'(ifu_resp_valid[1]), 32'd0);
    check_eq("mw_rst_ifu_rdata", ifu_rdata[1], 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifu_resp_valid[1]) hits++;
    end
    check_eq("mw_no_resp", 32'(hits), 32'd0);
    rd_word = 32'h33334444;
    run_req(1, 1, 0, 32'h44, 32'h0, 2'd0, 0,
            hs, en_cnt, en_c, rsp_c, rdata, err, msk, wd, ra, rwe, wrong);
    check_eq("mw_next_en_cyc", 32'(en_c), 32'(hs + 1));
    check_eq("mw_next_rsp_cyc", 32'(rsp_c), 32'(en_c + 3));
    check_eq("mw_next_rdata", rdata, 32'h33334444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
